// File: rtl/reorder_buffer.sv
// reorder_buffer: circular in-order reorder buffer for the Tomasulo core.
// Entries are allocated at the tail, filled out of order from the CDB, and
// retired one per cycle from the head. A mispredicted BRANCH/JALR at commit
// raises a flush pulse and empties the buffer.
// Optional feature macro: ROB_CDB_BYPASS_EN forwards a same-cycle CDB result
// into the operand queries.
module reorder_buffer #(
  parameter int RoB_WIDTH = 2,
  parameter int RoB_SIZE  = 1 << RoB_WIDTH,
  parameter int NON_DEP   = 1 << RoB_WIDTH
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 alloc_en,
  input  logic [1:0]           alloc_type,
  input  logic [4:0]           alloc_rd,
  input  logic [31:0]          alloc_pc,
  input  logic [31:0]          alloc_pred_pc,
  output logic [RoB_WIDTH-1:0] alloc_index,
  input  logic                 CDB_update_en,
  input  logic [RoB_WIDTH-1:0] CDB_update_index,
  input  logic [31:0]          CDB_update_data,
  input  logic [RoB_WIDTH-1:0] query_j_index,
  output logic                 query_j_ready,
  output logic [31:0]          query_j_data,
  input  logic [RoB_WIDTH-1:0] query_k_index,
  output logic                 query_k_ready,
  output logic [31:0]          query_k_data,
  output logic                 commit_en,
  output logic [4:0]           commit_rd,
  output logic [31:0]          commit_data,
  output logic [RoB_WIDTH-1:0] commit_robEntry,
  output logic                 flush_signal,
  output logic [31:0]          flush_pc,
  output logic                 isFull,
  output logic                 isEmpty
);

  typedef enum logic [1:0] {
    TYPE_ALU     = 2'd0,
    TYPE_BRANCH  = 2'd1,
    TYPE_JALR    = 2'd2,
    TYPE_ALU_ALT = 2'd3
  } rob_type_e;

  // NON_DEP equals the entry count, which is also the occupancy of a full buffer.
  localparam logic [RoB_WIDTH:0]   FULL_COUNT = NON_DEP[RoB_WIDTH:0];
  localparam logic [RoB_WIDTH:0]   CNT_ONE    = 1;
  localparam logic [RoB_WIDTH-1:0] PTR_ONE    = 1;

  logic [RoB_SIZE-1:0] busy;
  logic [RoB_SIZE-1:0] ready;
  rob_type_e           etype  [RoB_SIZE];
  logic [4:0]          erd    [RoB_SIZE];
  logic [31:0]         evalue [RoB_SIZE];
  logic [31:0]         epc    [RoB_SIZE];
  logic [31:0]         epred  [RoB_SIZE];

  logic [RoB_WIDTH-1:0] head;
  logic [RoB_WIDTH-1:0] tail;
  logic [RoB_WIDTH:0]   count;

  logic        do_alloc;
  logic        do_cdb;
  logic        do_commit;
  logic        do_flush;
  rob_type_e   head_type;
  logic [4:0]  commit_rd_next;
  logic [31:0] commit_data_next;

  assign alloc_index = tail;
  assign isFull      = (count == FULL_COUNT);
  assign isEmpty     = (count == '0);

  // Per-cycle decisions from registered state; rdy_in gating happens at the edge.
  always_comb begin
    head_type        = etype[head];
    do_commit        = busy[head] && ready[head];
    do_flush         = do_commit && (head_type == TYPE_BRANCH || head_type == TYPE_JALR)
                       && (evalue[head] != epred[head]);
    do_alloc         = alloc_en && !isFull && !flush_signal;
    do_cdb           = CDB_update_en && busy[CDB_update_index] && !flush_signal;
    commit_rd_next   = erd[head];
    commit_data_next = evalue[head];
    case (head_type)
      TYPE_BRANCH: commit_rd_next   = '0;
      TYPE_JALR:   commit_data_next = epc[head] + 32'd4;
      default:     ;
    endcase
  end

  // Operand lookups for the dispatcher.
  always_comb begin
    query_j_ready = busy[query_j_index] && ready[query_j_index];
    query_j_data  = query_j_ready ? evalue[query_j_index] : '0;
    query_k_ready = busy[query_k_index] && ready[query_k_index];
    query_k_data  = query_k_ready ? evalue[query_k_index] : '0;
`ifdef ROB_CDB_BYPASS_EN
    if (CDB_update_en && !flush_signal && (CDB_update_index == query_j_index)) begin
      query_j_ready = 1'b1;
      query_j_data  = CDB_update_data;
    end
    if (CDB_update_en && !flush_signal && (CDB_update_index == query_k_index)) begin
      query_k_ready = 1'b1;
      query_k_data  = CDB_update_data;
    end
`endif
  end

  // Entry storage, pointers, occupancy and registered commit/flush outputs.
  // Commit is applied after the CDB write so a CDB hit on the retiring head
  // leaves that slot cleared.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      busy            <= '0;
      ready           <= '0;
      for (int unsigned i = 0; i < RoB_SIZE; i++) begin
        etype[i]  <= TYPE_ALU;
        erd[i]    <= '0;
        evalue[i] <= '0;
        epc[i]    <= '0;
        epred[i]  <= '0;
      end
      head            <= '0;
      tail            <= '0;
      count           <= '0;
      commit_en       <= 1'b0;
      commit_rd       <= '0;
      commit_data     <= '0;
      commit_robEntry <= '0;
      flush_signal    <= 1'b0;
      flush_pc        <= '0;
    end else begin
      commit_en    <= 1'b0;
      flush_signal <= 1'b0;
      if (rdy_in) begin
        if (do_commit) begin
          commit_en       <= 1'b1;
          commit_rd       <= commit_rd_next;
          commit_data     <= commit_data_next;
          commit_robEntry <= head;
        end
        if (do_flush) begin
          flush_signal <= 1'b1;
          flush_pc     <= evalue[head];
          busy         <= '0;
          ready        <= '0;
          head         <= '0;
          tail         <= '0;
          count        <= '0;
        end else begin
          if (do_cdb) begin
            evalue[CDB_update_index] <= CDB_update_data;
            ready[CDB_update_index]  <= 1'b1;
          end
          if (do_alloc) begin
            busy[tail]  <= 1'b1;
            ready[tail] <= 1'b0;
            etype[tail] <= rob_type_e'(alloc_type);
            erd[tail]   <= alloc_rd;
            epc[tail]   <= alloc_pc;
            epred[tail] <= alloc_pred_pc;
            tail        <= tail + PTR_ONE;
          end
          if (do_commit) begin
            busy[head]  <= 1'b0;
            ready[head] <= 1'b0;
            head        <= head + PTR_ONE;
          end
          if (do_alloc && !do_commit) begin
            count <= count + CNT_ONE;
          end else if (!do_alloc && do_commit) begin
            count <= count - CNT_ONE;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios plus a randomized
// run compared against a queue-based model of the buffer's program-order rules.
module tb_reorder_buffer;
  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, alloc_en, CDB_update_en;
  logic [1:0]  alloc_type, alloc_index, CDB_update_index, query_j_index, query_k_index, commit_robEntry;
  logic [4:0]  alloc_rd, commit_rd;
  logic [31:0] alloc_pc, alloc_pred_pc, CDB_update_data, query_j_data, query_k_data, commit_data, flush_pc;
  logic        query_j_ready, query_k_ready, commit_en, flush_signal, isFull, isEmpty;

  int checks = 0;
  int failures = 0;

  always #5 clk_in = ~clk_in;

  reorder_buffer #(.RoB_WIDTH(2)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .alloc_en(alloc_en), .alloc_type(alloc_type), .alloc_rd(alloc_rd),
    .alloc_pc(alloc_pc), .alloc_pred_pc(alloc_pred_pc), .alloc_index(alloc_index),
    .CDB_update_en(CDB_update_en), .CDB_update_index(CDB_update_index), .CDB_update_data(CDB_update_data),
    .query_j_index(query_j_index), .query_j_ready(query_j_ready), .query_j_data(query_j_data),
    .query_k_index(query_k_index), .query_k_ready(query_k_ready), .query_k_data(query_k_data),
    .commit_en(commit_en), .commit_rd(commit_rd), .commit_data(commit_data), .commit_robEntry(commit_robEntry),
    .flush_signal(flush_signal), .flush_pc(flush_pc), .isFull(isFull), .isEmpty(isEmpty)
  );

  // ---------------- reference model: program-order queue ----------------
  typedef struct {
    int unsigned tag;
    int unsigned typ;
    logic [4:0]  rd;
    logic [31:0] pc, pred, val;
    bit          rdy;
  } ent_t;

  ent_t        mq[$];
  int unsigned m_tail;
  bit          m_flush_prev;
  bit          exp_commit_en, exp_flush;
  int unsigned exp_tag;
  logic [4:0]  exp_rd;
  logic [31:0] exp_data, exp_flush_pc;

  function automatic void model_reset();
    mq.delete(); m_tail = 0; m_flush_prev = 0;
    exp_commit_en = 0; exp_flush = 0; exp_tag = 0; exp_rd = 0; exp_data = 0; exp_flush_pc = 0;
  endfunction

  function automatic void model_edge();
    ent_t h;
    bit full_pre, flushed;
    full_pre = (mq.size() == 4);
    flushed = 0;
    exp_commit_en = 0; exp_flush = 0;
    if (rdy_in) begin
      if (mq.size() > 0 && mq[0].rdy) begin
        h = mq[0];
        exp_commit_en = 1;
        exp_tag  = h.tag;
        exp_rd   = (h.typ == 1) ? 5'd0 : h.rd;
        exp_data = (h.typ == 2) ? h.pc + 32'd4 : h.val;
        if ((h.typ == 1 || h.typ == 2) && h.val != h.pred) begin
          flushed = 1; exp_flush = 1; exp_flush_pc = h.val;
          mq.delete(); m_tail = 0;
        end else begin
          void'(mq.pop_front());
        end
      end
      if (!flushed && !m_flush_prev) begin
        if (CDB_update_en)
          foreach (mq[i]) if (mq[i].tag == CDB_update_index) begin mq[i].rdy = 1; mq[i].val = CDB_update_data; end
        if (alloc_en && !full_pre) begin
          h.tag = m_tail; h.typ = alloc_type; h.rd = alloc_rd; h.pc = alloc_pc;
          h.pred = alloc_pred_pc; h.val = 0; h.rdy = 0;
          mq.push_back(h);
          m_tail = (m_tail + 1) % 4;
        end
      end
    end
    m_flush_prev = exp_flush;
  endfunction

  function automatic void model_query(input logic [1:0] idx, output bit r, output logic [31:0] d);
    r = 0; d = 0;
    foreach (mq[i]) if (mq[i].tag == idx && mq[i].rdy) begin r = 1; d = mq[i].val; end
`ifdef ROB_CDB_BYPASS_EN
    if (CDB_update_en && CDB_update_index == idx && !m_flush_prev) begin r = 1; d = CDB_update_data; end
`endif
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic set_idle();
    rdy_in = 1; alloc_en = 0; alloc_type = 0; alloc_rd = 0; alloc_pc = 0; alloc_pred_pc = 0;
    CDB_update_en = 0; CDB_update_index = 0; CDB_update_data = 0; query_j_index = 0; query_k_index = 0;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk_in); #1;
  endtask

  task automatic apply_reset();
    set_idle(); rst_in = 1; #12; rst_in = 0;
    model_reset();
    @(posedge clk_in); #1;
  endtask

  task automatic do_alloc(input logic [1:0] t, input logic [4:0] rd, input logic [31:0] pc, input logic [31:0] pred);
    alloc_en = 1; alloc_type = t; alloc_rd = rd; alloc_pc = pc; alloc_pred_pc = pred;
    tick(); alloc_en = 0;
  endtask

  task automatic do_cdb(input logic [1:0] idx, input logic [31:0] data);
    CDB_update_en = 1; CDB_update_index = idx; CDB_update_data = data;
    tick(); CDB_update_en = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    apply_reset();
    checks++; if (commit_en !== 1'b0) begin failures++; $display("FAIL reset_commit_en got=%b exp=0", commit_en); end
    checks++; if (flush_signal !== 1'b0) begin failures++; $display("FAIL reset_flush got=%b exp=0", flush_signal); end
    checks++; if (flush_pc !== 32'd0) begin failures++; $display("FAIL reset_flush_pc got=%h exp=0", flush_pc); end
    checks++; if (commit_rd !== 5'd0 || commit_data !== 32'd0) begin failures++; $display("FAIL reset_commit_fields got=%0d/%h exp=0/0", commit_rd, commit_data); end
    checks++; if (isEmpty !== 1'b1 || isFull !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b%b exp=10", isEmpty, isFull); end
    checks++; if (alloc_index !== 2'd0) begin failures++; $display("FAIL reset_tail got=%0d exp=0", alloc_index); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    do_alloc(2'd0, 5'd6, 32'h10, 32'h0);
    do_cdb(2'd0, 32'hAB);
    rst_in = 1; #2;
    checks++; if (isEmpty !== 1'b1 || alloc_index !== 2'd0) begin failures++; $display("FAIL midreset_async got=%b/%0d exp=1/0", isEmpty, alloc_index); end
    @(posedge clk_in); #1;
    checks++; if (commit_en !== 1'b0 || flush_signal !== 1'b0) begin failures++; $display("FAIL midreset_pulse got=%b%b exp=00", commit_en, flush_signal); end
    rst_in = 0; model_reset();
    tick();
    checks++; if (commit_en !== 1'b0 || isEmpty !== 1'b1) begin failures++; $display("FAIL midreset_after got=%b/%b exp=0/1", commit_en, isEmpty); end
  endtask

  task automatic test_alloc_full();
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      checks++; if (alloc_index !== 2'(i)) begin failures++; $display("FAIL alloc_index got=%0d exp=%0d", alloc_index, i); end
      do_alloc(2'd0, 5'(i + 1), 32'h1000 + 32'(4 * i), 32'h0);
    end
    checks++; if (isFull !== 1'b1) begin failures++; $display("FAIL full_flag got=%b exp=1", isFull); end
    do_alloc(2'd0, 5'd9, 32'h2000, 32'h0);
    checks++; if (alloc_index !== 2'd0 || isFull !== 1'b1) begin failures++; $display("FAIL alloc_when_full got=%0d/%b exp=0/1", alloc_index, isFull); end
  endtask

  task automatic test_out_of_order();
    do_cdb(2'd2, 32'h22);
    checks++; if (commit_en !== 1'b0) begin failures++; $display("FAIL ooo_no_commit got=%b exp=0", commit_en); end
    do_cdb(2'd0, 32'h10);
    checks++; if (commit_en !== 1'b0) begin failures++; $display("FAIL ooo_latency got=%b exp=0", commit_en); end
    tick();
    checks++; if (commit_en !== 1'b1 || commit_rd !== 5'd1 || commit_data !== 32'h10 || commit_robEntry !== 2'd0) begin
      failures++; $display("FAIL ooo_commit0 got=%b rd=%0d data=%h tag=%0d exp=1 rd=1 data=10 tag=0", commit_en, commit_rd, commit_data, commit_robEntry); end
    tick();
    checks++; if (commit_en !== 1'b0) begin failures++; $display("FAIL ooo_stall got=%b exp=0", commit_en); end
    do_cdb(2'd1, 32'h11);
    tick();
    checks++; if (commit_en !== 1'b1 || commit_rd !== 5'd2 || commit_data !== 32'h11 || commit_robEntry !== 2'd1) begin
      failures++; $display("FAIL ooo_commit1 got=%b rd=%0d data=%h tag=%0d exp=1 rd=2 data=11 tag=1", commit_en, commit_rd, commit_data, commit_robEntry); end
    tick();
    checks++; if (commit_en !== 1'b1 || commit_rd !== 5'd3 || commit_data !== 32'h22 || commit_robEntry !== 2'd2) begin
      failures++; $display("FAIL ooo_commit2 got=%b rd=%0d data=%h tag=%0d exp=1 rd=3 data=22 tag=2", commit_en, commit_rd, commit_data, commit_robEntry); end
    tick();
    checks++; if (commit_en !== 1'b0) begin failures++; $display("FAIL ooo_tail_pending got=%b exp=0", commit_en); end
  endtask

  task automatic test_flush();
    apply_reset();
    do_alloc(2'd1, 5'd5, 32'h100, 32'h104);
    do_alloc(2'd0, 5'd7, 32'h104, 32'h0);
    do_cdb(2'd0, 32'h200);
    tick();
    checks++; if (commit_en !== 1'b1 || commit_rd !== 5'd0 || commit_data !== 32'h200) begin
      failures++; $display("FAIL flush_commit got=%b rd=%0d data=%h exp=1 rd=0 data=200", commit_en, commit_rd, commit_data); end
    checks++; if (flush_signal !== 1'b1 || flush_pc !== 32'h200) begin failures++; $display("FAIL flush_pulse got=%b pc=%h exp=1 pc=200", flush_signal, flush_pc); end
    checks++; if (isEmpty !== 1'b1 || alloc_index !== 2'd0) begin failures++; $display("FAIL flush_cleared got=%b/%0d exp=1/0", isEmpty, alloc_index); end
    CDB_update_en = 1; CDB_update_index = 2'd0; CDB_update_data = 32'h5;
    do_alloc(2'd0, 5'd3, 32'h200, 32'h0);
    CDB_update_en = 0;
    checks++; if (isEmpty !== 1'b1 || alloc_index !== 2'd0 || flush_signal !== 1'b0) begin
      failures++; $display("FAIL flush_cycle_alloc got=%b/%0d/%b exp=1/0/0", isEmpty, alloc_index, flush_signal); end
  endtask

  task automatic test_jalr();
    apply_reset();
    do_alloc(2'd2, 5'd1, 32'h40, 32'h80);
    do_cdb(2'd0, 32'h80);
    tick();
    checks++; if (commit_en !== 1'b1 || commit_rd !== 5'd1 || commit_data !== 32'h44 || flush_signal !== 1'b0) begin
      failures++; $display("FAIL jalr_commit got=%b rd=%0d data=%h fl=%b exp=1 rd=1 data=44 fl=0", commit_en, commit_rd, commit_data, flush_signal); end
  endtask

  task automatic test_wrap();
    logic [31:0] d;
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      d = $urandom;
      checks++; if (alloc_index !== 2'(i % 4)) begin failures++; $display("FAIL wrap_tag got=%0d exp=%0d", alloc_index, i % 4); end
      do_alloc(2'd0, 5'(i + 10), 32'h300, 32'h0);
      do_cdb(2'(i % 4), d);
      tick();
      checks++; if (commit_en !== 1'b1 || commit_robEntry !== 2'(i % 4) || commit_data !== d || commit_rd !== 5'(i + 10)) begin
        failures++; $display("FAIL wrap_commit got=%b tag=%0d data=%h exp=1 tag=%0d data=%h", commit_en, commit_robEntry, commit_data, i % 4, d); end
    end
    checks++; if (isEmpty !== 1'b1) begin failures++; $display("FAIL wrap_empty got=%b exp=1", isEmpty); end
  endtask

  task automatic test_query_and_pause();
    apply_reset();
    do_alloc(2'd0, 5'd3, 32'h500, 32'h0);
    do_alloc(2'd0, 5'd4, 32'h504, 32'h0);
    CDB_update_en = 1; CDB_update_index = 2'd1; CDB_update_data = 32'h55; query_j_index = 2'd1; query_k_index = 2'd0;
    #1;
`ifdef ROB_CDB_BYPASS_EN
    checks++; if (query_j_ready !== 1'b1 || query_j_data !== 32'h55) begin failures++; $display("FAIL query_bypass got=%b/%h exp=1/55", query_j_ready, query_j_data); end
`else
    checks++; if (query_j_ready !== 1'b0 || query_j_data !== 32'h0) begin failures++; $display("FAIL query_nobypass got=%b/%h exp=0/0", query_j_ready, query_j_data); end
`endif
    tick(); CDB_update_en = 0; #1;
    checks++; if (query_j_ready !== 1'b1 || query_j_data !== 32'h55) begin failures++; $display("FAIL query_after got=%b/%h exp=1/55", query_j_ready, query_j_data); end
    checks++; if (query_k_ready !== 1'b0 || query_k_data !== 32'h0) begin failures++; $display("FAIL query_k_pending got=%b/%h exp=0/0", query_k_ready, query_k_data); end
    do_cdb(2'd0, 32'h66);
    rdy_in = 0; alloc_en = 1; alloc_rd = 5'd9;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (commit_en !== 1'b0 || alloc_index !== 2'd2 || isEmpty !== 1'b0) begin
        failures++; $display("FAIL pause_hold got=%b/%0d/%b exp=0/2/0", commit_en, alloc_index, isEmpty); end
    end
    rdy_in = 1; alloc_en = 0;
    tick();
    checks++; if (commit_en !== 1'b1 || commit_robEntry !== 2'd0 || commit_data !== 32'h66 || commit_rd !== 5'd3) begin
      failures++; $display("FAIL resume_commit0 got=%b tag=%0d data=%h exp=1 tag=0 data=66", commit_en, commit_robEntry, commit_data); end
    tick();
    checks++; if (commit_en !== 1'b1 || commit_robEntry !== 2'd1 || commit_data !== 32'h55 || commit_rd !== 5'd4) begin
      failures++; $display("FAIL resume_commit1 got=%b tag=%0d data=%h exp=1 tag=1 data=55", commit_en, commit_robEntry, commit_data); end
    tick();
    checks++; if (commit_en !== 1'b0 || isEmpty !== 1'b1) begin failures++; $display("FAIL resume_drained got=%b/%b exp=0/1", commit_en, isEmpty); end
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      int pend[$];
      int p;
      bit r;
      logic [31:0] d;
      rdy_in = ($urandom_range(9) != 0);
      alloc_en = $urandom_range(1); alloc_type = 2'($urandom_range(3)); alloc_rd = 5'($urandom);
      alloc_pc = $urandom & 32'hFFFF_FFFC;
      alloc_pred_pc = $urandom_range(1) ? alloc_pc + 32'd4 : ($urandom & 32'hFFFF_FFFC);
      foreach (mq[i]) if (!mq[i].rdy) pend.push_back(i);
      CDB_update_en = ($urandom_range(3) != 0);
      if (pend.size() > 0 && $urandom_range(4) != 0) begin
        p = pend[$urandom_range(pend.size() - 1)];
        CDB_update_index = 2'(mq[p].tag);
        CDB_update_data = ((mq[p].typ == 1 || mq[p].typ == 2) && $urandom_range(9) < 7) ? mq[p].pred : $urandom;
      end else begin
        CDB_update_index = 2'($urandom_range(3)); CDB_update_data = $urandom;
      end
      query_j_index = 2'($urandom_range(3)); query_k_index = 2'($urandom_range(3));
      #1;
      model_query(query_j_index, r, d);
      checks++; if (query_j_ready !== r || query_j_data !== d) begin failures++; $display("FAIL rnd_query_j c=%0d got=%b/%h exp=%b/%h", c, query_j_ready, query_j_data, r, d); end
      model_query(query_k_index, r, d);
      checks++; if (query_k_ready !== r || query_k_data !== d) begin failures++; $display("FAIL rnd_query_k c=%0d got=%b/%h exp=%b/%h", c, query_k_ready, query_k_data, r, d); end
      tick();
      checks++; if (commit_en !== exp_commit_en || flush_signal !== exp_flush) begin
        failures++; $display("FAIL rnd_pulses c=%0d got=%b%b exp=%b%b", c, commit_en, flush_signal, exp_commit_en, exp_flush); end
      if (exp_commit_en) begin
        checks++; if (commit_rd !== exp_rd || commit_data !== exp_data || commit_robEntry !== 2'(exp_tag)) begin
          failures++; $display("FAIL rnd_commit c=%0d got=%0d/%h/%0d exp=%0d/%h/%0d", c, commit_rd, commit_data, commit_robEntry, exp_rd, exp_data, exp_tag); end
      end
      if (exp_flush) begin
        checks++; if (flush_pc !== exp_flush_pc) begin failures++; $display("FAIL rnd_flush_pc c=%0d got=%h exp=%h", c, flush_pc, exp_flush_pc); end
      end
      checks++; if (isEmpty !== (mq.size() == 0) || isFull !== (mq.size() == 4) || alloc_index !== 2'(m_tail)) begin
        failures++; $display("FAIL rnd_occupancy c=%0d got=%b%b/%0d exp=%b%b/%0d", c, isEmpty, isFull, alloc_index, mq.size() == 0, mq.size() == 4, m_tail); end
    end
  endtask

  initial begin
    set_idle();
    rst_in = 1;
    test_reset();
    test_reset_mid();
    test_alloc_full();
    test_out_of_order();
    test_flush();
    test_jalr();
    test_wrap();
    test_query_and_pause();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
